// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter.
//   state_e - arbiter FSM states (IDLE, WAIT_BUSY, WAIT_DONE)
//   BYTE_W  - width of one transmitted byte
//   clog2   - ceiling log2, used to size grant and counter fields
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-source and transmitter handshake bundle of the arbiter.
//   i_req_valid / i_req_data - per-source byte strobes, byte n at [8n+7:8n]
//   o_req_full / o_overflow  - per-source slot occupancy and sticky drop flag
//   o_tx_DATA_READY / o_tx_DATA / i_tx_BUSY / i_tx_DONE - transmitter handshake
//   o_grant_id / o_timeout / o_active - last served source, abandon pulse, FSM not idle
//   slave  - arbiter side; master - environment side (sources and transmitter)
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import uart_pkg::*;

    localparam int GW = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        i_req_valid;
    logic [BYTE_W*NUM_REQ-1:0] i_req_data;
    logic [NUM_REQ-1:0]        o_req_full;
    logic [NUM_REQ-1:0]        o_overflow;
    logic                      o_tx_DATA_READY;
    logic [BYTE_W-1:0]         o_tx_DATA;
    logic                      i_tx_BUSY;
    logic                      i_tx_DONE;
    logic [GW-1:0]             o_grant_id;
    logic                      o_timeout;
    logic                      o_active;

    modport slave (
        input  i_req_valid, i_req_data, i_tx_BUSY, i_tx_DONE,
        output o_req_full, o_overflow, o_tx_DATA_READY, o_tx_DATA,
               o_grant_id, o_timeout, o_active
    );

    modport master (
        output i_req_valid, i_req_data, i_tx_BUSY, i_tx_DONE,
        input  o_req_full, o_overflow, o_tx_DATA_READY, o_tx_DATA,
               o_grant_id, o_timeout, o_active
    );

endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker over the slot-full vector.
//   full_i  - slot n holds a byte
//   last_i  - index of the last served source; search starts just after it
//   found_o - at least one slot is full
//   win_o   - first full slot at or after last_i+1, wrapping
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = clog2(N)
) (
    input  logic [N-1:0]  full_i,
    input  logic [GW-1:0] last_i,
    output logic          found_o,
    output logic [GW-1:0] win_o
);

    logic [GW-1:0] idx;

    // Walking the offsets from farthest to nearest lets the nearest full slot win.
    always_comb begin
        found_o = |full_i;
        win_o   = '0;
        idx     = '0;
        for (int k = N; k >= 1; k--) begin
            idx = GW'((int'(last_i) + k) % N);
            if (full_i[idx]) win_o = idx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte sources.
//   i_CLK   - single clock, rising edge
//   i_RESET - synchronous active-high reset; drops pending and in-flight bytes
//   bus     - slave side of uart_tx_arbiter_if: source strobes, slot status,
//             transmitter launch/busy/done handshake, grant, timeout, activity
// Each source owns a one-byte slot; a round-robin pick launches one held byte
// at a time and then waits for the transmitter to report busy and done.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic           i_CLK,
    input  logic           i_RESET,
    uart_tx_arbiter_if.slave bus
);

    localparam int GW = clog2(NUM_REQ);
    localparam int CW = clog2(BUSY_TIMEOUT + 1);

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [NUM_REQ-1:0]  full_q, full_d;
    logic [NUM_REQ-1:0]  ovf_q, ovf_d;
    logic [BYTE_W-1:0]   data_q [NUM_REQ];
    logic [BYTE_W-1:0]   data_d [NUM_REQ];
    logic                dr_q;
    logic [BYTE_W-1:0]   txd_q;
    logic [GW-1:0]       gid_q;
    logic                to_q;
    logic                found;
    logic [GW-1:0]       win;
    logic                launch;

    uart_rr_pick #(.N(NUM_REQ), .GW(GW)) u_pick (
        .full_i  (full_q),
        .last_i  (gid_q),
        .found_o (found),
        .win_o   (win)
    );

    assign launch = (state_q == IDLE) && found && !bus.i_tx_BUSY;

    // The launched slot is cleared first so a strobe in the launch cycle refills it.
    always_comb begin
        full_d = full_q;
        ovf_d  = ovf_q;
        data_d = data_q;
        if (launch) full_d[win] = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (bus.i_req_valid[n]) begin
                if (!full_d[n]) begin
                    full_d[n] = 1'b1;
                    data_d[n] = bus.i_req_data[n*BYTE_W +: BYTE_W];
                end else begin
                    ovf_d[n] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            full_q  <= '0;
            ovf_q   <= '0;
            data_q  <= '{default: '0};
            dr_q    <= 1'b0;
            txd_q   <= '0;
            gid_q   <= GW'(NUM_REQ - 1);
            to_q    <= 1'b0;
        end else begin
            full_q <= full_d;
            ovf_q  <= ovf_d;
            data_q <= data_d;
            dr_q   <= launch;
            to_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        txd_q   <= data_q[win];
                        gid_q   <= win;
                        cnt_q   <= '0;
                        state_q <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.i_tx_DONE) begin
                        state_q <= IDLE;
                    end else if (bus.i_tx_BUSY) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                        // Pulse lands BUSY_TIMEOUT cycles after the launch strobe.
                        to_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WAIT_DONE: state_q <= bus.i_tx_DONE ? IDLE : WAIT_DONE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_req_full      = full_q;
    assign bus.o_overflow      = ovf_q;
    assign bus.o_tx_DATA_READY = dr_q;
    assign bus.o_tx_DATA       = txd_q;
    assign bus.o_grant_id      = gid_q;
    assign bus.o_timeout       = to_q;
    assign bus.o_active        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter (two sources).
module tb_uart_tx_arbiter;

    localparam int N = 2;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(T)) dut (
        .i_CLK   (clk),
        .i_RESET (rst),
        .bus     (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each slot either holds a byte or not; one byte may be
    // in flight, abandoned T cycles after its strobe unless busy/done is seen.
    bit [N-1:0] m_full, m_ovf;
    bit [7:0]   m_byte [N];
    bit         m_dr, m_to, m_inflight, m_saw_busy;
    bit [7:0]   m_txd;
    int         m_gid, m_launch_cyc;

    task automatic model_next(input bit r, input bit [1:0] v, input bit [7:0] d0, input bit [7:0] d1,
                              input bit b, input bit dn);
        int w;
        bit launch;
        bit [N-1:0] nfull;
        bit [7:0] d [N];
        d[0] = d0;
        d[1] = d1;
        if (r) begin
            m_full = '0; m_ovf = '0; m_dr = 0; m_to = 0; m_inflight = 0; m_saw_busy = 0;
            m_txd = 0; m_gid = N - 1;
            m_byte[0] = 0; m_byte[1] = 0;
            return;
        end
        w = -1;
        for (int k = 1; k <= N; k++)
            if (w < 0 && m_full[(m_gid + k) % N]) w = (m_gid + k) % N;
        launch = !m_inflight && w >= 0 && !b;
        nfull = m_full;
        m_dr = launch;
        m_to = 0;
        if (launch) begin
            m_txd = m_byte[w];
            m_gid = w;
            nfull[w] = 0;
            m_inflight = 1;
            m_saw_busy = 0;
            m_launch_cyc = cyc + 1;
        end else if (m_inflight) begin
            if (dn) m_inflight = 0;
            else if (!m_saw_busy && b) m_saw_busy = 1;
            else if (!m_saw_busy && cyc + 1 - m_launch_cyc == T) begin
                m_to = 1;
                m_inflight = 0;
            end
        end
        for (int n = 0; n < N; n++)
            if (v[n]) begin
                if (!m_full[n] || (launch && w == n)) begin
                    nfull[n] = 1;
                    m_byte[n] = d[n];
                end else m_ovf[n] = 1;
            end
        m_full = nfull;
    endtask

    task automatic check_model();
        cmp("full",    int'(bus.o_req_full),      int'(m_full));
        cmp("ovf",     int'(bus.o_overflow),      int'(m_ovf));
        cmp("dr",      int'(bus.o_tx_DATA_READY), int'(m_dr));
        cmp("txd",     int'(bus.o_tx_DATA),       int'(m_txd));
        cmp("gid",     int'(bus.o_grant_id),      m_gid);
        cmp("timeout", int'(bus.o_timeout),       int'(m_to));
        cmp("active",  int'(bus.o_active),        int'(m_inflight));
    endtask

    // Called at a falling edge: drive inputs, advance the model, check at the next falling edge.
    task automatic step(input bit r, input bit [1:0] v, input bit [7:0] d0, input bit [7:0] d1,
                        input bit b, input bit dn);
        rst = r;
        bus.i_req_valid = v;
        bus.i_req_data  = {d1, d0};
        bus.i_tx_BUSY   = b;
        bus.i_tx_DONE   = dn;
        model_next(r, v, d0, d1, b, dn);
        @(negedge clk);
        cyc++;
        check_model();
    endtask

    typedef struct packed {
        bit       rst;
        bit [1:0] v;
        bit [7:0] d0, d1;
        bit       busy, done;
        bit       dr;
        bit [7:0] txd;
        bit       gid;
        bit [1:0] full, ovf;
        bit       to, act;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int k;
        int tx_s, tx_e, mode;
        bit b, dn, r;
        bit [1:0] v;

        //          rst v      d0     d1     bsy dn  | dr txd   gid full   ovf    to act
        tbl[0]  = '{1, 2'b00, 8'h00, 8'h00, 0, 0,     0, 8'h00, 1, 2'b00, 2'b00, 0, 0};
        tbl[1]  = '{0, 2'b01, 8'h41, 8'h00, 0, 0,     0, 8'h00, 1, 2'b01, 2'b00, 0, 0};
        tbl[2]  = '{0, 2'b00, 8'h00, 8'h00, 0, 0,     1, 8'h41, 0, 2'b00, 2'b00, 0, 1};
        tbl[3]  = '{0, 2'b00, 8'h00, 8'h00, 1, 0,     0, 8'h41, 0, 2'b00, 2'b00, 0, 1};
        tbl[4]  = '{0, 2'b00, 8'h00, 8'h00, 1, 0,     0, 8'h41, 0, 2'b00, 2'b00, 0, 1};
        tbl[5]  = '{0, 2'b00, 8'h00, 8'h00, 0, 1,     0, 8'h41, 0, 2'b00, 2'b00, 0, 0};
        tbl[6]  = '{0, 2'b00, 8'h00, 8'h00, 0, 0,     0, 8'h41, 0, 2'b00, 2'b00, 0, 0};
        tbl[7]  = '{1, 2'b00, 8'h00, 8'h00, 0, 0,     0, 8'h00, 1, 2'b00, 2'b00, 0, 0};
        tbl[8]  = '{0, 2'b11, 8'hA5, 8'h5A, 0, 0,     0, 8'h00, 1, 2'b11, 2'b00, 0, 0};
        tbl[9]  = '{0, 2'b00, 8'h00, 8'h00, 0, 0,     1, 8'hA5, 0, 2'b10, 2'b00, 0, 1};
        tbl[10] = '{0, 2'b00, 8'h00, 8'h00, 1, 0,     0, 8'hA5, 0, 2'b10, 2'b00, 0, 1};
        tbl[11] = '{0, 2'b00, 8'h00, 8'h00, 0, 1,     0, 8'hA5, 0, 2'b10, 2'b00, 0, 0};
        tbl[12] = '{0, 2'b00, 8'h00, 8'h00, 0, 0,     1, 8'h5A, 1, 2'b00, 2'b00, 0, 1};
        tbl[13] = '{0, 2'b00, 8'h00, 8'h00, 1, 1,     0, 8'h5A, 1, 2'b00, 2'b00, 0, 0};
        tbl[14] = '{0, 2'b11, 8'hB1, 8'hB2, 0, 0,     0, 8'h5A, 1, 2'b11, 2'b00, 0, 0};
        tbl[15] = '{0, 2'b00, 8'h00, 8'h00, 0, 0,     1, 8'hB1, 0, 2'b10, 2'b00, 0, 1};
        tbl[16] = '{0, 2'b00, 8'h00, 8'h00, 0, 1,     0, 8'hB1, 0, 2'b10, 2'b00, 0, 0};
        tbl[17] = '{0, 2'b00, 8'h00, 8'h00, 0, 0,     1, 8'hB2, 1, 2'b00, 2'b00, 0, 1};
        tbl[18] = '{0, 2'b00, 8'h00, 8'h00, 0, 1,     0, 8'hB2, 1, 2'b00, 2'b00, 0, 0};

        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        bus.i_tx_BUSY   = 1'b0;
        bus.i_tx_DONE   = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            rst             = tbl[i].rst;
            bus.i_req_valid = tbl[i].v;
            bus.i_req_data  = {tbl[i].d1, tbl[i].d0};
            bus.i_tx_BUSY   = tbl[i].busy;
            bus.i_tx_DONE   = tbl[i].done;
            @(negedge clk);
            cyc++;
            cmp($sformatf("vec%0d dr", i),      int'(bus.o_tx_DATA_READY), int'(tbl[i].dr));
            cmp($sformatf("vec%0d txd", i),     int'(bus.o_tx_DATA),       int'(tbl[i].txd));
            cmp($sformatf("vec%0d gid", i),     int'(bus.o_grant_id),      int'(tbl[i].gid));
            cmp($sformatf("vec%0d full", i),    int'(bus.o_req_full),      int'(tbl[i].full));
            cmp($sformatf("vec%0d ovf", i),     int'(bus.o_overflow),      int'(tbl[i].ovf));
            cmp($sformatf("vec%0d timeout", i), int'(bus.o_timeout),       int'(tbl[i].to));
            cmp($sformatf("vec%0d active", i),  int'(bus.o_active),        int'(tbl[i].act));
        end

        // Overflow while the transmitter is busy with another byte.
        step(1, 2'b00, 8'h00, 8'h00, 0, 0);
        step(0, 2'b01, 8'h77, 8'h00, 0, 0);
        step(0, 2'b00, 8'h00, 8'h00, 0, 0);
        step(0, 2'b10, 8'h00, 8'h11, 1, 0);
        step(0, 2'b10, 8'h00, 8'h22, 1, 0);
        step(0, 2'b00, 8'h00, 8'h00, 1, 0);
        step(0, 2'b00, 8'h00, 8'h00, 0, 1);
        step(0, 2'b00, 8'h00, 8'h00, 0, 0);
        cmp("ovf_sent_dr",  int'(bus.o_tx_DATA_READY), 1);
        cmp("ovf_sent_byte", int'(bus.o_tx_DATA), 8'h11);
        step(0, 2'b00, 8'h00, 8'h00, 1, 0);
        step(0, 2'b00, 8'h00, 8'h00, 0, 1);
        step(0, 2'b00, 8'h00, 8'h00, 0, 0);
        step(0, 2'b00, 8'h00, 8'h00, 0, 0);
        cmp("ovf_sticky", int'(bus.o_overflow), 2'b10);
        cmp("ovf_no_22", int'(bus.o_req_full), 0);

        // Refill in the launch cycle of the same slot.
        step(1, 2'b00, 8'h00, 8'h00, 0, 0);
        step(0, 2'b01, 8'h32, 8'h00, 0, 0);
        step(0, 2'b01, 8'h33, 8'h00, 0, 0);
        cmp("refill_byte", int'(bus.o_tx_DATA), 8'h32);
        cmp("refill_full", int'(bus.o_req_full), 2'b01);
        cmp("refill_ovf", int'(bus.o_overflow), 0);
        step(0, 2'b00, 8'h00, 8'h00, 0, 1);
        step(0, 2'b00, 8'h00, 8'h00, 0, 0);
        cmp("refill_second", int'(bus.o_tx_DATA), 8'h33);
        step(0, 2'b00, 8'h00, 8'h00, 0, 1);

        // Transmitter never answers: launch is abandoned after T cycles.
        step(1, 2'b00, 8'h00, 8'h00, 0, 0);
        step(0, 2'b11, 8'hC0, 8'hC1, 0, 0);
        step(0, 2'b00, 8'h00, 8'h00, 0, 0);
        cmp("to_launch", int'(bus.o_tx_DATA), 8'hC0);
        k = 0;
        do begin
            step(0, 2'b00, 8'h00, 8'h00, 0, 0);
            k++;
        end while (!bus.o_timeout && k < 2 * T);
        cmp("to_latency", k, T);
        step(0, 2'b00, 8'h00, 8'h00, 0, 0);
        cmp("to_next_dr", int'(bus.o_tx_DATA_READY), 1);
        cmp("to_next_byte", int'(bus.o_tx_DATA), 8'hC1);
        step(0, 2'b00, 8'h00, 8'h00, 0, 1);

        // Reset while waiting for done with both slots full.
        step(1, 2'b00, 8'h00, 8'h00, 0, 0);
        step(0, 2'b11, 8'hD0, 8'hD1, 0, 0);
        step(0, 2'b00, 8'h00, 8'h00, 0, 0);
        step(0, 2'b00, 8'h00, 8'h00, 1, 0);
        step(0, 2'b01, 8'hD2, 8'h00, 1, 0);
        cmp("mid_full_pre", int'(bus.o_req_full), 2'b11);
        step(1, 2'b00, 8'h00, 8'h00, 0, 0);
        cmp("mid_full",   int'(bus.o_req_full), 0);
        cmp("mid_txd",    int'(bus.o_tx_DATA), 0);
        cmp("mid_gid",    int'(bus.o_grant_id), N - 1);
        cmp("mid_active", int'(bus.o_active), 0);

        // Randomized traffic with a reactive transmitter model.
        tx_s = -5;
        tx_e = -5;
        for (int i = 0; i < 3000; i++) begin
            r = (i % 700 == 699);
            b = !r && cyc >= tx_s && cyc < tx_e;
            dn = !r && cyc == tx_e;
            v[0] = ($urandom_range(0, 3) == 0);
            v[1] = ($urandom_range(0, 3) == 0);
            step(r, v, 8'($urandom), 8'($urandom), b, dn);
            if (r) begin
                tx_s = -5;
                tx_e = -5;
            end else if (m_dr) begin
                mode = $urandom_range(0, 5);
                tx_s = cyc + $urandom_range(0, 3);
                tx_e = (mode == 0) ? -5 : (mode == 1) ? tx_s : tx_s + $urandom_range(1, 5);
                if (mode == 0) tx_s = -5;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
